ddr_ca_tx_lane_ctrl: RTL
========================

Name: ddr_ca_tx_lane_ctrl

Overview:
- Multi-pin DDR address/command transmit controller that sits between the fabric-side DDR controller and a bank of NUM_PINS output-only IOD lanes.
- Registers GEAR-beat transmit data, per-pin output enables and ODT enable toward the lanes.
- Owns every lane's dynamic output delay line: tracks the current tap code per pin and executes absolute, increment, decrement and reload commands as timed LOAD/MOVE/DIRECTION sequences, with out-of-range detection.

Parameters:
NUM_PINS, 16, number of address/command lanes
GEAR, 4, data beats per FAB_CLK per pin
TAP_W, 7, tap code width
MAX_TAP, 127, highest legal tap code
DEFAULT_TAP, 1, tap value after a delay-line load
MOVE_GAP, 2, idle cycles after each MOVE pulse (>=1)

Ports:
FAB_CLK  in  1  sole clock
ARST  in  1  asynchronous reset, active-high
TX_DATA_IN  in  NUM_PINS*GEAR  beat data; pin p uses bits [p*GEAR +: GEAR]
OE_IN  in  NUM_PINS  per-pin output enable
ODT_EN_IN  in  1  ODT enable
TX_DATA_OUT  out  NUM_PINS*GEAR  registered beat data to lanes
OE_DATA_OUT  out  NUM_PINS*GEAR  OE_IN[p] replicated across the pin's GEAR beats
ODT_EN_OUT  out  1  registered ODT enable
CMD_VALID  in  1  delay command valid
CMD_READY  out  1  controller can accept a command
CMD_PIN  in  $clog2(NUM_PINS)  target pin
CMD_OP  in  2  00 absolute, 01 increment, 10 decrement, 11 reload
CMD_TAP  in  TAP_W  absolute target code
DELAY_LINE_MOVE  out  NUM_PINS  per-pin move strobe
DELAY_LINE_DIRECTION  out  NUM_PINS  per-pin direction (1 = increment)
DELAY_LINE_LOAD  out  NUM_PINS  per-pin load strobe
DELAY_LINE_OUT_OF_RANGE  in  NUM_PINS  per-pin out-of-range flag from lane
DONE  out  1  one-cycle command-complete pulse
ERR  out  1  valid with DONE; command failed
STAT_TAP  out  TAP_W  tracked tap of the command's pin, valid with DONE
BUSY  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: all outputs 0 except BUSY=1; all tracked taps = DEFAULT_TAP; state = INIT. All outputs are registered.
- Data path: one-cycle registered latency, independent of the FSM. OE_DATA_OUT and ODT_EN_OUT are forced to 0 while ARST is high.
- FSM states: INIT, IDLE, LOAD, SETUP, STEP, GAP, FIN.
- INIT: first cycle after reset release, DELAY_LINE_LOAD is all-ones for exactly 1 cycle, then IDLE.
- IDLE: CMD_READY=1. A command is accepted on CMD_VALID & CMD_READY in cycle 0; CMD_READY drops the next cycle. Inputs are captured at acceptance.
- Target computation:
  - absolute: CMD_TAP.
  - increment: tap+1.
  - decrement: tap-1.
  - reload: go to LOAD, which pulses DELAY_LINE_LOAD[pin] for 1 cycle, sets tap to DEFAULT_TAP, then FIN.
- Illegal commands go directly to FIN with ERR=1 and no strobes, tap unchanged:
  - absolute with CMD_TAP > MAX_TAP;
  - increment at MAX_TAP;
  - decrement at 0.
- Target equal to the current tap: FIN with ERR=0 and no strobes.
- Stepping, one step per iteration:
  - SETUP: DIRECTION[pin] driven, MOVE low.
  - STEP: MOVE[pin]=1 for exactly 1 cycle, then tap +/-1.
  - GAP: MOVE_GAP cycles.
  - Then FIN if tap equals target, otherwise SETUP.
- DIRECTION[pin] holds from the first SETUP through the last GAP; all other pins' DIRECTION and MOVE bits stay 0.
- Out-of-range: if DELAY_LINE_OUT_OF_RANGE[pin] is high in the last GAP cycle, abort to FIN with ERR=1. The tap keeps its value including the failed step.
- FIN: DONE=1, STAT_TAP=tap[pin] for 1 cycle, then IDLE.
- Latency: DONE occurs in cycle k*(2+MOVE_GAP)+1 for k steps; k=0 gives cycle 1. Reload gives DONE in cycle 2.
- ARST mid-operation: strobes drop immediately, taps revert to DEFAULT_TAP, FSM restarts at INIT.
- CMD_PIN >= NUM_PINS: ERR=1, no strobes.

Test Plan:
- Reset release -> DELAY_LINE_LOAD=16'hFFFF for 1 cycle; then CMD_READY=1, BUSY=0, all OE_DATA_OUT=0 until OE_IN rises.
- Default params, absolute CMD_TAP=4 on pin 3 -> 3 MOVE[3] pulses 4 cycles apart with DIRECTION[3]=1; DONE in cycle 13, STAT_TAP=4, ERR=0.
- Pin 3 at 4, decrement -> 1 MOVE pulse with DIRECTION[3]=0; DONE in cycle 5, STAT_TAP=3.
- Absolute CMD_TAP=127 on pin 0, with OUT_OF_RANGE[0] forced high after the 10th MOVE -> DONE with ERR=1, STAT_TAP=11.
- Absolute 127 done, then increment -> DONE in cycle 1, ERR=1, no strobes; reload -> LOAD[pin] pulse, STAT_TAP=1.
- ARST asserted in the middle of a 20-step move -> MOVE goes low, INIT load repeats, later readback of that pin's tap = 1; TX_DATA_OUT follows TX_DATA_IN with 1-cycle latency throughout.

Source files
------------

// File: rtl/ddr_ca_tx_lane_ctrl.sv
// DDR address/command transmit lane controller: registers beat data, OE and ODT
// toward the IOD lanes and sequences every lane's dynamic output delay line.
//
// state | meaning
// INIT  | after reset: load every delay line to its default tap
// IDLE  | ready for a delay command
// LOAD  | reload one pin's delay line to the default tap
// SETUP | drive direction for the next step, move low
// STEP  | one-cycle move strobe
// GAP   | settle time after a move, out-of-range sampled on its last cycle
// FIN   | report done / error / tracked tap
module ddr_ca_tx_lane_ctrl #(
    parameter int NUM_PINS    = 16,
    parameter int GEAR        = 4,
    parameter int TAP_W       = 7,
    parameter int MAX_TAP     = 127,
    parameter int DEFAULT_TAP = 1,
    parameter int MOVE_GAP    = 2
) (
    input  logic                          FAB_CLK,
    input  logic                          ARST,
    input  logic [NUM_PINS*GEAR-1:0]      TX_DATA_IN,
    input  logic [NUM_PINS-1:0]           OE_IN,
    input  logic                          ODT_EN_IN,
    output logic [NUM_PINS*GEAR-1:0]      TX_DATA_OUT,
    output logic [NUM_PINS*GEAR-1:0]      OE_DATA_OUT,
    output logic                          ODT_EN_OUT,
    input  logic                          CMD_VALID,
    output logic                          CMD_READY,
    input  logic [$clog2(NUM_PINS)-1:0]   CMD_PIN,
    input  logic [1:0]                    CMD_OP,
    input  logic [TAP_W-1:0]              CMD_TAP,
    output logic [NUM_PINS-1:0]           DELAY_LINE_MOVE,
    output logic [NUM_PINS-1:0]           DELAY_LINE_DIRECTION,
    output logic [NUM_PINS-1:0]           DELAY_LINE_LOAD,
    input  logic [NUM_PINS-1:0]           DELAY_LINE_OUT_OF_RANGE,
    output logic                          DONE,
    output logic                          ERR,
    output logic [TAP_W-1:0]              STAT_TAP,
    output logic                          BUSY
);

    localparam int PIN_W = $clog2(NUM_PINS);
    localparam int GAP_W = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
    localparam logic [TAP_W-1:0] TAP_DEF  = TAP_W'(DEFAULT_TAP);
    localparam logic [TAP_W-1:0] TAP_MAX  = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] TAP_ONE  = TAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MOVE_GAP - 1);

    localparam logic [1:0] OP_ABS = 2'b00;
    localparam logic [1:0] OP_INC = 2'b01;
    localparam logic [1:0] OP_DEC = 2'b10;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOAD,
        SETUP,
        STEP,
        GAP,
        FIN
    } state_t;

    state_t             state_q, state_d;
    logic               init_armed_q;
    logic [PIN_W-1:0]   pin_q, pin_d;
    logic [TAP_W-1:0]   tgt_q, tgt_d;
    logic               dir_q, dir_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    logic [TAP_W-1:0]   tap_q [NUM_PINS];

    logic               pin_ok;
    logic [TAP_W-1:0]   cur_tap;
    logic [TAP_W-1:0]   tap_sel;
    logic [TAP_W-1:0]   tgt_calc;
    logic               cmd_bad;
    logic               cmd_reload;
    logic               fin_err;
    logic [TAP_W-1:0]   stat_d;

    logic [NUM_PINS-1:0]      pin_bit;
    logic [NUM_PINS-1:0]      move_d;
    logic [NUM_PINS-1:0]      dirv_d;
    logic [NUM_PINS-1:0]      load_d;
    logic [NUM_PINS*GEAR-1:0] oe_rep;

    // ---------------------------------------------------------------- data path
    always_comb begin
        oe_rep = '0;
        for (int p = 0; p < NUM_PINS; p++) begin
            oe_rep[p*GEAR +: GEAR] = {GEAR{OE_IN[p]}};
        end
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            TX_DATA_OUT <= '0;
            OE_DATA_OUT <= '0;
            ODT_EN_OUT  <= 1'b0;
        end else begin
            TX_DATA_OUT <= TX_DATA_IN;
            OE_DATA_OUT <= oe_rep;
            ODT_EN_OUT  <= ODT_EN_IN;
        end
    end

    // ---------------------------------------------------------- command decode
    always_comb begin
        pin_ok     = ({1'b0, CMD_PIN} < (PIN_W+1)'(NUM_PINS));
        cur_tap    = pin_ok ? tap_q[CMD_PIN] : '0;
        tgt_calc   = cur_tap;
        cmd_bad    = 1'b0;
        cmd_reload = 1'b0;
        case (CMD_OP)
            OP_ABS: begin
                tgt_calc = CMD_TAP;
                cmd_bad  = ({1'b0, CMD_TAP} > (TAP_W+1)'(MAX_TAP));
            end
            OP_INC: begin
                tgt_calc = cur_tap + TAP_ONE;
                cmd_bad  = (cur_tap >= TAP_MAX);
            end
            OP_DEC: begin
                tgt_calc = cur_tap - TAP_ONE;
                cmd_bad  = (cur_tap == '0);
            end
            default: cmd_reload = 1'b1;
        endcase
    end

    assign tap_sel = tap_q[pin_q];

    // ------------------------------------------------------- next state / outs
    always_comb begin
        state_d = state_q;
        pin_d   = pin_q;
        tgt_d   = tgt_q;
        dir_d   = dir_q;
        gap_d   = gap_q;
        fin_err = 1'b0;
        stat_d  = STAT_TAP;
        case (state_q)
            INIT: begin
                if (init_armed_q) state_d = IDLE;
            end
            IDLE: begin
                if (CMD_VALID && CMD_READY) begin
                    pin_d = CMD_PIN;
                    if (!pin_ok || cmd_bad) begin
                        state_d = FIN;
                        fin_err = 1'b1;
                        stat_d  = cur_tap;
                    end else if (cmd_reload) begin
                        state_d = LOAD;
                    end else if (tgt_calc == cur_tap) begin
                        state_d = FIN;
                        stat_d  = cur_tap;
                    end else begin
                        state_d = SETUP;
                        tgt_d   = tgt_calc;
                        dir_d   = (tgt_calc > cur_tap);
                    end
                end
            end
            LOAD: begin
                state_d = FIN;
                stat_d  = TAP_DEF;
            end
            SETUP: state_d = STEP;
            STEP: begin
                state_d = GAP;
                gap_d   = GAP_LAST;
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - GAP_W'(1);
                end else if (DELAY_LINE_OUT_OF_RANGE[pin_q]) begin
                    state_d = FIN;
                    fin_err = 1'b1;
                    stat_d  = tap_sel;
                end else if (tap_sel == tgt_q) begin
                    state_d = FIN;
                    stat_d  = tap_sel;
                end else begin
                    state_d = SETUP;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = INIT;
        endcase
    end

    // Strobes are decoded from the next state so every output is a flop.
    always_comb begin
        pin_bit        = '0;
        pin_bit[pin_d] = 1'b1;
        move_d         = (state_d == STEP) ? pin_bit : '0;
        dirv_d         = (dir_d && (state_d == SETUP || state_d == STEP || state_d == GAP))
                         ? pin_bit : '0;
        load_d         = '0;
        if (state_d == INIT)      load_d = '1;
        else if (state_d == LOAD) load_d = pin_bit;
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            state_q              <= INIT;
            init_armed_q         <= 1'b0;
            pin_q                <= '0;
            tgt_q                <= '0;
            dir_q                <= 1'b0;
            gap_q                <= '0;
            CMD_READY            <= 1'b0;
            BUSY                 <= 1'b1;
            DONE                 <= 1'b0;
            ERR                  <= 1'b0;
            STAT_TAP             <= '0;
            DELAY_LINE_MOVE      <= '0;
            DELAY_LINE_DIRECTION <= '0;
            DELAY_LINE_LOAD      <= '0;
        end else begin
            state_q              <= state_d;
            init_armed_q         <= 1'b1;
            pin_q                <= pin_d;
            tgt_q                <= tgt_d;
            dir_q                <= dir_d;
            gap_q                <= gap_d;
            CMD_READY            <= (state_d == IDLE);
            BUSY                 <= (state_d != IDLE);
            DONE                 <= (state_d == FIN);
            ERR                  <= fin_err;
            STAT_TAP             <= stat_d;
            DELAY_LINE_MOVE      <= move_d;
            DELAY_LINE_DIRECTION <= dirv_d;
            DELAY_LINE_LOAD      <= load_d;
        end
    end

    // Tracked taps mirror the lanes: the step is counted even if it was flagged out of range.
    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            for (int p = 0; p < NUM_PINS; p++) tap_q[p] <= TAP_DEF;
        end else begin
            case (state_q)
                INIT: for (int p = 0; p < NUM_PINS; p++) tap_q[p] <= TAP_DEF;
                LOAD: tap_q[pin_q] <= TAP_DEF;
                STEP: tap_q[pin_q] <= dir_q ? (tap_sel + TAP_ONE) : (tap_sel - TAP_ONE);
                default: ;
            endcase
        end
    end

endmodule
